// File: rtl/counter_pkg.sv
// Shared definitions for counter-sequence checkers: FSM states and common widths.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam int ERR_CNT_W = 8;
  // Wide enough for LOCK_N up to 15.
  localparam int GOOD_W    = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; an increment coincident with a
// clear restarts the count at one.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (inc) begin
      if (clr) begin
        value <= W'(1);
      end else if (value != {W{1'b1}}) begin
        value <= value + W'(1);
      end
    end else if (clr) begin
      value <= '0;
    end
  end

endmodule

// File: rtl/counter_checker.sv
// Watches an external counter and flags any break in its +1 sequence once a
// run of LOCK_N correct increments has been seen.
// Handshake: sample_en is a valid-only qualifier (no ready); count_in is taken
// on every rising edge where sample_en=1, and nothing changes otherwise.
module counter_checker
  import counter_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int LOCK_N = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_en,
  input  logic [WIDTH-1:0]     count_in,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err_pulse,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   ref_q, ref_d;
  logic [GOOD_W-1:0]  good_q, good_d;
  logic [WIDTH-1:0]   expected;
  logic               mismatch;

  // Natural WIDTH-bit wrap makes all-ones -> zero a correct step.
  assign expected = ref_q + WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    good_d   = good_q;
    mismatch = 1'b0;
    if (sample_en) begin
      ref_d = count_in;
      unique case (state_q)
        IDLE: begin
          good_d  = '0;
          state_d = SYNC;
        end
        SYNC: begin
          if (count_in == expected) begin
            good_d = good_q + GOOD_W'(1);
            if (good_q == GOOD_W'(LOCK_N - 1)) state_d = LOCKED;
          end else begin
            good_d = '0;
          end
        end
        LOCKED: begin
          if (count_in != expected) begin
            mismatch = 1'b1;
            good_d   = '0;
            state_d  = SYNC;
          end
        end
        default: begin
          good_d  = '0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ref_q      <= '0;
      good_q     <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      good_q    <= good_d;
      locked    <= (state_d == LOCKED);
      err_pulse <= mismatch;
      // A mismatch in the same cycle as a clear wins.
      if (mismatch) begin
        err_sticky <= 1'b1;
      end else if (clr_err) begin
        err_sticky <= 1'b0;
      end
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .inc  (mismatch),
    .clr  (clr_err),
    .value(err_cnt)
  );

endmodule

// File: doc/counter_checker.md
COUNTER_CHECKER -- requirements
Module: counter_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the width of the observed count.
REQ-002 The module SHALL have parameter LOCK_N, default 2, giving the consecutive correct increments required to lock (range 1..15).
REQ-003 The port clk SHALL be an input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-004 The port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 The port sample_en SHALL be an input, 1 bit: count_in is valid this cycle.
REQ-006 The port count_in SHALL be an input, WIDTH bits: the observed counter value.
REQ-007 The port clr_err SHALL be an input, 1 bit: a synchronous clear of err_cnt and err_sticky.
REQ-008 The port locked SHALL be an output, 1 bit: the checker is tracking a valid sequence.
REQ-009 The port err_pulse SHALL be an output, 1 bit: a one-cycle mismatch indication.
REQ-010 The port err_sticky SHALL be an output, 1 bit: at least one mismatch has occurred since reset or clear.
REQ-011 The port err_cnt SHALL be an output, 8 bits: a saturating mismatch count.

Function
REQ-012 All outputs SHALL be registered, and SHALL be updated on the rising clk edge at which the qualifying sample (sample_en=1) is taken.
REQ-013 The checker SHALL implement three states:
- IDLE: no reference value held.
- SYNC: reference held, good-run counter < LOCK_N.
- LOCKED: good-run counter has reached LOCK_N.
REQ-014 In IDLE, a sample SHALL store count_in as the reference, clear the good-run counter and move to SYNC, with no error.
REQ-015 The expected value SHALL be (reference + 1) mod 2^WIDTH, so the wrap from all-ones to zero is correct.
REQ-016 In SYNC:
- A correct sample SHALL increment the good-run counter and update the reference.
- On reaching LOCK_N, the state SHALL move to LOCKED.
- An incorrect sample SHALL reseed the reference, clear the good-run counter and stay in SYNC, with no error.
REQ-017 In LOCKED:
- A correct sample SHALL update the reference.
- An incorrect sample, including a held (repeated) value, SHALL assert err_pulse for exactly one cycle, increment err_cnt, set err_sticky, reseed the reference with count_in and move to SYNC.
REQ-018 The output locked SHALL be 1 exactly while the state is LOCKED.
REQ-019 When sample_en=0, the state, reference and counters SHALL hold, and err_pulse SHALL be 0.
REQ-020 err_cnt SHALL saturate at 255; a further mismatch SHALL leave it at 255 while still pulsing err_pulse.
REQ-021 When clr_err is asserted alone, err_cnt SHALL become 0 and err_sticky SHALL become 0 on the next edge; clr_err SHALL NOT affect the state or locked.
REQ-022 When clr_err and a mismatch occur in the same cycle, the mismatch SHALL win: err_cnt=1, err_sticky=1, err_pulse=1.
REQ-023 A count_in jump to 0 caused by a counter reset SHALL be treated as an ordinary mismatch when LOCKED.

Reset
REQ-024 On rst_n=0, regardless of clk, the following SHALL take effect immediately:
- State = IDLE; reference and good-run counter = 0.
- locked=0, err_pulse=0, err_sticky=0, err_cnt=0.
REQ-025 An assertion of rst_n mid-sequence SHALL discard lock and error history.
REQ-026 The first sample after deassertion SHALL be handled as in IDLE.
REQ-027 The design SHALL synchronise rst_n deassertion externally; no internal synchroniser is required.

Structure
REQ-028 A shared package counter_pkg SHALL hold the following, for reuse by counter and future checkers:
- the state enumeration (IDLE, SYNC, LOCKED);
- the localparam ERR_CNT_W=8.
REQ-029 The mismatch counter SHALL be a sub-module sat_counter (width parameter, inc, clr, inc-over-clr priority, saturating), instantiated once.
REQ-030 No other hierarchy is needed.

Verification
REQ-031 Scenario "clean count": reset, then samples 0..15,0..3 every cycle -> locked=1 from the 3rd sample edge onward, err_pulse never 1, err_cnt=0.
REQ-032 Scenario "skip": locked on 4,5,6, then drive 8 -> err_pulse=1 for one cycle, err_cnt=1, err_sticky=1, locked=0; then 9,10 -> locked=1 again.
REQ-033 Scenario "mid-run counter reset": locked at value 9, then drive 0,1,2 -> one error and relock after 2; sample_en low for 5 cycles in between -> no state change.
REQ-034 Scenario "saturation and clear": force 260 mismatches -> err_cnt=255; pulse clr_err alone -> err_cnt=0 and sticky=0; clr_err coincident with a mismatch -> err_cnt=1.
REQ-035 Scenario "async reset": assert rst_n low between clock edges while locked -> all outputs 0 immediately; after release, first sample 7 causes no error.
